// File: rtl/stream_pkg.sv
// Shared definitions for the stream_* blocks: FSM encoding and default widths.
package stream_pkg;

    localparam int DEF_DATA_WD = 4;

    // Code 2'd3 is never entered; the skid slice decodes it back to ST_EMPTY.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } skid_st_e;

endpackage

// File: rtl/stream_pkt_cnt.sv
// Wrapping packet counter with increment enable; shared by slice/join/fork blocks.
module stream_pkt_cnt #(
    parameter int CNT_WD = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              inc,
    output logic [CNT_WD-1:0] cnt
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + CNT_WD'(1);
    end

endmodule

// File: rtl/stream_skid_slice.sv
// Two-entry registered skid buffer: re-times c_* onto d_* with no combinational
// path between the two sides, carrying a last flag and counting packets out.
module stream_skid_slice
    import stream_pkg::*;
#(
    parameter int DATA_WD = DEF_DATA_WD,
    parameter int CNT_WD  = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [DATA_WD-1:0] c_data,
    input  logic               c_last,
    input  logic               c_valid,
    output logic               c_ready,
    output logic [DATA_WD-1:0] d_data,
    output logic               d_last,
    output logic               d_valid,
    input  logic               d_ready,
    output logic [CNT_WD-1:0]  pkt_cnt
);

    skid_st_e           state, state_nxt;
    logic [DATA_WD-1:0] m_data, s_data;
    logic               m_last, s_last;
    logic               c_ready_q, d_valid_q;
    logic               c_fire, d_fire;
    logic               ld_main_c, ld_main_s, ld_skid;

    assign c_fire = c_valid & c_ready_q;
    assign d_fire = d_valid_q & d_ready;

    always_comb begin
        state_nxt = state;
        ld_main_c = 1'b0;
        ld_main_s = 1'b0;
        ld_skid   = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (c_fire) begin
                    state_nxt = ST_BUSY;
                    ld_main_c = 1'b1;
                end
            end
            ST_BUSY: begin
                case ({c_fire, d_fire})
                    2'b10: begin
                        state_nxt = ST_FULL;
                        ld_skid   = 1'b1;
                    end
                    2'b11:   ld_main_c = 1'b1;
                    2'b01:   state_nxt = ST_EMPTY;
                    default: state_nxt = ST_BUSY;
                endcase
            end
            // c_ready is low here, so only the drain of main can happen.
            ST_FULL: begin
                if (d_fire) begin
                    state_nxt = ST_BUSY;
                    ld_main_s = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_EMPTY;
            c_ready_q <= 1'b0;
            d_valid_q <= 1'b0;
            m_data    <= '0;
            m_last    <= 1'b0;
            s_data    <= '0;
            s_last    <= 1'b0;
        end else begin
            state     <= state_nxt;
            c_ready_q <= (state_nxt != ST_FULL);
            d_valid_q <= (state_nxt != ST_EMPTY);
            if (ld_main_c) begin
                m_data <= c_data;
                m_last <= c_last;
            end else if (ld_main_s) begin
                m_data <= s_data;
                m_last <= s_last;
            end
            if (ld_skid) begin
                s_data <= c_data;
                s_last <= c_last;
            end
        end
    end

    assign c_ready = c_ready_q;
    assign d_valid = d_valid_q;
    assign d_data  = m_data;
    assign d_last  = m_last;

    stream_pkt_cnt #(.CNT_WD(CNT_WD)) u_pkt_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (d_fire & m_last),
        .cnt  (pkt_cnt)
    );

endmodule

// File: tb/tb_stream_skid_slice.sv
// Directed bench for stream_skid_slice, plus a narrow-counter instance for wrap.
module tb_stream_skid_slice;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] c_data, d_data;
    logic       c_last, c_valid, c_ready, d_last, d_valid, d_ready;
    logic [7:0] pkt_cnt;

    logic [3:0] c2_data, d2_data;
    logic       c2_last, c2_valid, c2_ready, d2_last, d2_valid, d2_ready;
    logic [1:0] pkt_cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    stream_skid_slice #(.DATA_WD(4), .CNT_WD(8)) dut (
        .clk(clk), .rstn(rstn),
        .c_data(c_data), .c_last(c_last), .c_valid(c_valid), .c_ready(c_ready),
        .d_data(d_data), .d_last(d_last), .d_valid(d_valid), .d_ready(d_ready),
        .pkt_cnt(pkt_cnt)
    );

    stream_skid_slice #(.DATA_WD(4), .CNT_WD(2)) dut2 (
        .clk(clk), .rstn(rstn),
        .c_data(c2_data), .c_last(c2_last), .c_valid(c2_valid), .c_ready(c2_ready),
        .d_data(d2_data), .d_last(d2_last), .d_valid(d2_valid), .d_ready(d2_ready),
        .pkt_cnt(pkt_cnt2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; c_valid = 1'b1; c_data = 4'h9; c_last = 1'b0; d_ready = 1'b1;
        c2_valid = 1'b0; c2_data = 4'h0; c2_last = 1'b0; d2_ready = 1'b1;
        tick(); tick();
        n_cmp++; if (c_ready !== 1'b0) begin n_bad++; $display("FAIL reset.c_ready got %b exp 0", c_ready); end
        n_cmp++; if (d_valid !== 1'b0) begin n_bad++; $display("FAIL reset.d_valid got %b exp 0", d_valid); end
        n_cmp++; if (pkt_cnt !== 8'd0) begin n_bad++; $display("FAIL reset.pkt_cnt got %0d exp 0", pkt_cnt); end
        n_cmp++; if ({d_last, d_data} !== 5'd0) begin n_bad++; $display("FAIL reset.d_data got %0h exp 0", {d_last, d_data}); end
        c_valid = 1'b0;
        rstn = 1'b1;
        #1;
        n_cmp++; if (c_ready !== 1'b0) begin n_bad++; $display("FAIL reset.c_ready_pre_edge got %b exp 0", c_ready); end
        tick();
        n_cmp++; if (c_ready !== 1'b1) begin n_bad++; $display("FAIL reset.c_ready_after_edge got %b exp 1", c_ready); end
        n_cmp++; if (d_valid !== 1'b0) begin n_bad++; $display("FAIL reset.d_valid_after got %b exp 0", d_valid); end
    endtask

    task automatic test_stream();
        d_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            c_valid = 1'b1; c_data = 4'(i); c_last = (i == 8);
            tick();
            n_cmp++;
            if (d_valid !== 1'b1 || d_data !== 4'(i) || d_last !== (i == 8) || c_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL stream.beat%0d got v=%b d=%0h l=%b r=%b exp v=1 d=%0h l=%b r=1",
                         i, d_valid, d_data, d_last, c_ready, i, (i == 8));
            end
        end
        n_cmp++; if (pkt_cnt !== 8'd0) begin n_bad++; $display("FAIL stream.pkt_cnt_early got %0d exp 0", pkt_cnt); end
        c_valid = 1'b0; c_last = 1'b0;
        tick();
        n_cmp++; if (d_valid !== 1'b0) begin n_bad++; $display("FAIL stream.drain_valid got %b exp 0", d_valid); end
        n_cmp++; if (pkt_cnt !== 8'd1) begin n_bad++; $display("FAIL stream.pkt_cnt got %0d exp 1", pkt_cnt); end
    endtask

    task automatic test_backpressure();
        d_ready = 1'b0; c_valid = 1'b1; c_data = 4'h3; c_last = 1'b0;
        tick();
        n_cmp++; if (d_valid !== 1'b1 || d_data !== 4'h3 || c_ready !== 1'b1) begin
            n_bad++; $display("FAIL bp.first got v=%b d=%0h r=%b exp v=1 d=3 r=1", d_valid, d_data, c_ready); end
        c_data = 4'h4;
        tick();
        n_cmp++; if (d_valid !== 1'b1 || d_data !== 4'h3 || c_ready !== 1'b0) begin
            n_bad++; $display("FAIL bp.full got v=%b d=%0h r=%b exp v=1 d=3 r=0", d_valid, d_data, c_ready); end
        c_data = 4'h5;
        tick();
        n_cmp++; if (d_valid !== 1'b1 || d_data !== 4'h3 || c_ready !== 1'b0) begin
            n_bad++; $display("FAIL bp.hold got v=%b d=%0h r=%b exp v=1 d=3 r=0", d_valid, d_data, c_ready); end
        c_valid = 1'b0; d_ready = 1'b1;
        tick();
        n_cmp++; if (d_valid !== 1'b1 || d_data !== 4'h4 || c_ready !== 1'b1) begin
            n_bad++; $display("FAIL bp.skid_out got v=%b d=%0h r=%b exp v=1 d=4 r=1", d_valid, d_data, c_ready); end
        tick();
        n_cmp++; if (d_valid !== 1'b0 || pkt_cnt !== 8'd1) begin
            n_bad++; $display("FAIL bp.empty got v=%b cnt=%0d exp v=0 cnt=1", d_valid, pkt_cnt); end
    endtask

    task automatic test_random();
        logic [4:0] q[$];
        logic [4:0] exp_beat, held_beat;
        logic [3:0] seq;
        logic       cf, df, held;
        int         exp_pkt;
        int         beats;
        seq = 4'h0; held = 1'b0; held_beat = '0; exp_pkt = 1; beats = 0;
        for (int cyc = 0; cyc < 1600; cyc++) begin
            if (cyc < 1580) begin
                c_valid = ($urandom_range(0, 1) == 1);
                d_ready = ($urandom_range(0, 1) == 1);
            end else begin
                c_valid = 1'b0;
                d_ready = 1'b1;
            end
            c_data = seq;
            c_last = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (held) begin
                n_cmp++;
                if (d_valid !== 1'b1 || {d_last, d_data} !== held_beat) begin
                    n_bad++;
                    $display("FAIL rand.stable cyc=%0d got v=%b beat=%0h exp v=1 beat=%0h",
                             cyc, d_valid, {d_last, d_data}, held_beat);
                end
            end
            cf = c_valid & c_ready;
            df = d_valid & d_ready;
            held = d_valid & !d_ready;
            held_beat = {d_last, d_data};
            if (df) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL rand.extra_beat cyc=%0d got beat=%0h exp none", cyc, {d_last, d_data});
                end else begin
                    exp_beat = q.pop_front();
                    if ({d_last, d_data} !== exp_beat) begin
                        n_bad++;
                        $display("FAIL rand.order cyc=%0d got beat=%0h exp %0h", cyc, {d_last, d_data}, exp_beat);
                    end
                    if (exp_beat[4]) exp_pkt++;
                    beats++;
                end
            end
            if (cf) begin
                q.push_back({c_last, c_data});
                seq = seq + 4'd1;
            end
            tick();
        end
        n_cmp++; if (q.size() != 0 || d_valid !== 1'b0) begin
            n_bad++; $display("FAIL rand.drain got left=%0d v=%b exp left=0 v=0", q.size(), d_valid); end
        n_cmp++; if (pkt_cnt !== 8'(exp_pkt)) begin
            n_bad++; $display("FAIL rand.pkt_cnt got %0d exp %0d", pkt_cnt, 8'(exp_pkt)); end
        n_cmp++; if (beats < 200) begin
            n_bad++; $display("FAIL rand.throughput got %0d beats exp >=200", beats); end
    endtask

    task automatic test_cnt_wrap();
        logic [1:0] exp_cnt [5];
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd0; exp_cnt[4] = 2'd1;
        d2_ready = 1'b1;
        for (int p = 0; p < 5; p++) begin
            c2_valid = 1'b1; c2_data = 4'(p); c2_last = 1'b1;
            tick();
            c2_valid = 1'b0; c2_last = 1'b0;
            tick();
            n_cmp++;
            if (pkt_cnt2 !== exp_cnt[p] || d2_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL wrap.pkt%0d got cnt=%0d v=%b exp cnt=%0d v=0", p, pkt_cnt2, d2_valid, exp_cnt[p]);
            end
        end
    endtask

    task automatic test_reset_full();
        d_ready = 1'b0; c_valid = 1'b1; c_last = 1'b1; c_data = 4'hA;
        tick();
        c_data = 4'hB;
        tick();
        n_cmp++; if (c_ready !== 1'b0 || d_data !== 4'hA) begin
            n_bad++; $display("FAIL rstfull.setup got r=%b d=%0h exp r=0 d=a", c_ready, d_data); end
        c_valid = 1'b0; c_last = 1'b0;
        #2 rstn = 1'b0;
        #1;
        n_cmp++; if (d_valid !== 1'b0 || pkt_cnt !== 8'd0 || d_data !== 4'h0) begin
            n_bad++; $display("FAIL rstfull.async got v=%b cnt=%0d d=%0h exp v=0 cnt=0 d=0", d_valid, pkt_cnt, d_data); end
        tick();
        rstn = 1'b1; d_ready = 1'b1;
        tick();
        n_cmp++; if (c_ready !== 1'b1 || d_valid !== 1'b0) begin
            n_bad++; $display("FAIL rstfull.release got r=%b v=%b exp r=1 v=0", c_ready, d_valid); end
        tick();
        n_cmp++; if (d_valid !== 1'b0) begin
            n_bad++; $display("FAIL rstfull.no_skid got v=%b d=%0h exp v=0", d_valid, d_data); end
        c_valid = 1'b1; c_data = 4'hC; c_last = 1'b1;
        tick();
        n_cmp++; if (d_valid !== 1'b1 || d_data !== 4'hC || d_last !== 1'b1) begin
            n_bad++; $display("FAIL rstfull.restart got v=%b d=%0h l=%b exp v=1 d=c l=1", d_valid, d_data, d_last); end
        c_valid = 1'b0; c_last = 1'b0;
        tick();
        n_cmp++; if (d_valid !== 1'b0 || pkt_cnt !== 8'd1) begin
            n_bad++; $display("FAIL rstfull.done got v=%b cnt=%0d exp v=0 cnt=1", d_valid, pkt_cnt); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_random();
        test_cnt_wrap();
        test_reset_full();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
